cam_dvp_tx: RTL and testbench



---
 rtl/cam_dvp_tx_pkg.sv | 27 ++
 rtl/cam_dvp_timing.sv | 94 +++++++++
 rtl/cam_dvp_tx.sv | 121 ++++++++++++
 tb/tb_cam_dvp_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_dvp_tx_pkg.sv
// Shared DVP transmitter definitions: state encoding, default frame timing and the test-pattern byte.
// The camera receive bench imports this as well, so both sides agree on encodings and timing.
package cam_dvp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5
    } state_t;

    localparam int DEF_H_ACTIVE      = 1280;
    localparam int DEF_H_BLANK       = 144;
    localparam int DEF_V_ACTIVE      = 480;
    localparam int DEF_VSYNC_LINES   = 3;
    localparam int DEF_V_BACK_LINES  = 17;
    localparam int DEF_V_FRONT_LINES = 10;
    localparam int DEF_CW            = 16;

    // Diagonal ramp: each line is the previous one shifted by one count.
    function automatic logic [7:0] pattern_byte(input logic [7:0] h, input logic [7:0] v);
        return h + v;
    endfunction

endpackage

// File: rtl/cam_dvp_timing.sv
// Frame timing state machine for the DVP transmitter: walks VSYNC/VBACK/ACTIVE/HBLANK/VFRONT
// with a line-position counter (hcnt) and a per-state line counter (vcnt).
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | stopped, counters held at zero
// ST_VSYNC  | VSYNC_LINES line periods with VSYNC asserted
// ST_VBACK  | V_BACK_LINES line periods before the first active line
// ST_ACTIVE | data slots of an active line (hcnt < H_ACTIVE)
// ST_HBLANK | horizontal blanking tail of an active line
// ST_VFRONT | V_FRONT_LINES line periods after the last active line
module cam_dvp_timing
    import cam_dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE      = DEF_H_ACTIVE,
    parameter int H_BLANK       = DEF_H_BLANK,
    parameter int V_ACTIVE      = DEF_V_ACTIVE,
    parameter int VSYNC_LINES   = DEF_VSYNC_LINES,
    parameter int V_BACK_LINES  = DEF_V_BACK_LINES,
    parameter int V_FRONT_LINES = DEF_V_FRONT_LINES,
    parameter int CW            = DEF_CW
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic          start_go,
    input  logic          stop_pending,
    output state_t        state,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt,
    output logic          slot,
    output logic          frame_end
);

    localparam int LINE_LEN = H_ACTIVE + H_BLANK;
    localparam logic [CW-1:0] H_LAST     = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] VS_LAST    = CW'(VSYNC_LINES - 1);
    localparam logic [CW-1:0] VB_LAST    = CW'(V_BACK_LINES - 1);
    localparam logic [CW-1:0] VA_LAST    = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] VF_LAST    = CW'(V_FRONT_LINES - 1);

    state_t        state_nxt;
    logic [CW-1:0] hcnt_nxt;
    logic [CW-1:0] vcnt_nxt;
    logic          line_end;

    assign line_end = (hcnt == H_LAST);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state <= ST_IDLE;
            hcnt  <= '0;
            vcnt  <= '0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            vcnt  <= vcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hcnt_nxt  = '0;
        vcnt_nxt  = '0;
        if (state != ST_IDLE) begin
            hcnt_nxt = line_end ? '0 : hcnt + 1'b1;
        end
        unique case (state)
            ST_IDLE:   if (start_go) state_nxt = ST_VSYNC;
            ST_VSYNC:  if (line_end && vcnt == VS_LAST) state_nxt = ST_VBACK;
            ST_VBACK:  if (line_end && vcnt == VB_LAST) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (hcnt == H_ACT_LAST) state_nxt = ST_HBLANK;
            ST_HBLANK: if (line_end) state_nxt = (vcnt == VA_LAST) ? ST_VFRONT : ST_ACTIVE;
            ST_VFRONT: if (line_end && vcnt == VF_LAST) state_nxt = stop_pending ? ST_IDLE : ST_VSYNC;
            default:   state_nxt = ST_IDLE;
        endcase
        // HBLANK -> ACTIVE is a new line of the same active region, so it counts up instead of clearing.
        if (state == ST_IDLE) begin
            vcnt_nxt = '0;
        end else if (!line_end) begin
            vcnt_nxt = vcnt;
        end else if (state == ST_HBLANK) begin
            vcnt_nxt = (state_nxt == ST_ACTIVE) ? vcnt + 1'b1 : '0;
        end else begin
            vcnt_nxt = (state_nxt == state) ? vcnt + 1'b1 : '0;
        end
    end

    always_comb begin
        slot      = (state == ST_ACTIVE);
        frame_end = (state == ST_VFRONT) && line_end && (vcnt == VF_LAST);
    end

endmodule

// File: rtl/cam_dvp_tx.sv
// DVP camera-port transmitter: frames a byte stream or a test pattern into VSYNC/HREF/D on pclk,
// with start/stop commands and frame status.
module cam_dvp_tx
    import cam_dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE      = DEF_H_ACTIVE,
    parameter int H_BLANK       = DEF_H_BLANK,
    parameter int V_ACTIVE      = DEF_V_ACTIVE,
    parameter int VSYNC_LINES   = DEF_VSYNC_LINES,
    parameter int V_BACK_LINES  = DEF_V_BACK_LINES,
    parameter int V_FRONT_LINES = DEF_V_FRONT_LINES,
    parameter int CW            = DEF_CW
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        pattern_en,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_din,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        underflow
);

    generate
        if (H_ACTIVE < 1 || H_BLANK < 1 || V_ACTIVE < 1 || VSYNC_LINES < 1 ||
            V_BACK_LINES < 1 || V_FRONT_LINES < 1) begin : g_bad_count
            $error("cam_dvp_tx: every timing count must be at least 1");
        end
        if (CW < 8 || CW > 31) begin : g_bad_cw
            $error("cam_dvp_tx: CW must be in 8..31");
        end else if ((H_ACTIVE + H_BLANK) >= (1 << CW) || V_ACTIVE >= (1 << CW) ||
                     VSYNC_LINES >= (1 << CW) || V_BACK_LINES >= (1 << CW) ||
                     V_FRONT_LINES >= (1 << CW)) begin : g_bad_range
            $error("cam_dvp_tx: line length and line counts must fit in CW bits");
        end
    endgenerate

    state_t        state;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          slot;
    logic          frame_end;
    logic          start_go;
    logic          stop_pending;
    logic          pattern_lat;
    logic [7:0]    slot_byte;
    logic [15:0]   frame_cnt_q;
    logic          cnt_hi_unused;

    // stop wins over a simultaneous start so a stuck-high start line cannot override a stop request.
    assign start_go      = (state == ST_IDLE) && start && !stop;
    assign busy          = (state != ST_IDLE);
    assign pix_ready     = slot && !pattern_lat;
    assign frame_done    = frame_end;
    assign frame_cnt     = frame_cnt_q;
    assign cnt_hi_unused = ^{hcnt[CW-1:8], vcnt[CW-1:8]};

    cam_dvp_timing #(
        .H_ACTIVE      (H_ACTIVE),
        .H_BLANK       (H_BLANK),
        .V_ACTIVE      (V_ACTIVE),
        .VSYNC_LINES   (VSYNC_LINES),
        .V_BACK_LINES  (V_BACK_LINES),
        .V_FRONT_LINES (V_FRONT_LINES),
        .CW            (CW)
    ) u_timing (
        .pclk         (pclk),
        .rst          (rst),
        .start_go     (start_go),
        .stop_pending (stop_pending),
        .state        (state),
        .hcnt         (hcnt),
        .vcnt         (vcnt),
        .slot         (slot),
        .frame_end    (frame_end)
    );

    always_comb begin
        slot_byte = 8'h00;
        if (pattern_lat) begin
            slot_byte = pattern_byte(hcnt[7:0], vcnt[7:0]);
        end else if (pix_valid) begin
            slot_byte = pix_data;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            stop_pending <= 1'b0;
            pattern_lat  <= 1'b0;
            underflow    <= 1'b0;
            frame_cnt_q  <= 16'h0000;
            cam_vsync    <= 1'b0;
            cam_href     <= 1'b0;
            cam_din      <= 8'h00;
        end else begin
            cam_vsync <= (state == ST_VSYNC);
            cam_href  <= slot;
            cam_din   <= slot ? slot_byte : 8'h00;
            if (start_go) begin
                stop_pending <= 1'b0;
                underflow    <= 1'b0;
                pattern_lat  <= pattern_en;
            end else begin
                if (busy && stop) stop_pending <= 1'b1;
                if (frame_end && !stop_pending) pattern_lat <= pattern_en;
                // HREF is never stretched: a missing byte goes out as zero and is flagged.
                if (slot && !pattern_lat && !pix_valid) underflow <= 1'b1;
            end
            if (frame_end) frame_cnt_q <= frame_cnt_q + 16'h0001;
        end
    end

endmodule

// File: tb/tb_cam_dvp_tx.sv
// Directed bench for cam_dvp_tx on a 6-cycle line / 30-cycle frame; cycle 0 is the first VSYNC state cycle.
module tb_cam_dvp_tx;

    logic        pclk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        pattern_en;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_din;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        underflow;

    cam_dvp_tx #(
        .H_ACTIVE      (4),
        .H_BLANK       (2),
        .V_ACTIVE      (2),
        .VSYNC_LINES   (1),
        .V_BACK_LINES  (1),
        .V_FRONT_LINES (1),
        .CW            (16)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pattern_en (pattern_en),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_din    (cam_din),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .underflow  (underflow)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    typedef struct {
        int         scen;
        int         cyc;
        logic       vsync;
        logic       href;
        logic [7:0] din;
        logic       fdone;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    logic        cv [0:127];
    logic        ch [0:127];
    logic [7:0]  cd [0:127];
    logic        cf [0:127];
    logic        cb [0:127];
    logic        cr [0:127];
    logic        cu [0:127];
    logic [15:0] cc [0:127];

    function automatic void add(input int s, input int c, input logic v, input logic h,
                                input logic [7:0] d, input logic f);
        vec_t e;
        e.scen = s; e.cyc = c; e.vsync = v; e.href = h; e.din = d; e.fdone = f;
        tbl.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_table(input int scen, input string tag);
        foreach (tbl[i]) begin
            if (tbl[i].scen == scen) begin
                chk($sformatf("%s c%0d vsync", tag, tbl[i].cyc), 16'(cv[tbl[i].cyc]), 16'(tbl[i].vsync));
                chk($sformatf("%s c%0d href", tag, tbl[i].cyc), 16'(ch[tbl[i].cyc]), 16'(tbl[i].href));
                chk($sformatf("%s c%0d din", tag, tbl[i].cyc), 16'(cd[tbl[i].cyc]), 16'(tbl[i].din));
                chk($sformatf("%s c%0d frame_done", tag, tbl[i].cyc), 16'(cf[tbl[i].cyc]), 16'(tbl[i].fdone));
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        repeat (2) @(posedge pclk);
        #1 rst = 1'b0;
    endtask

    // Pulses start, then samples outputs for n cycles. pattern_en is flipped after the start edge
    // so that a frame only honours the value latched at its own start.
    task automatic run(input int n, input logic pat, input int drop_slot,
                       input int stop_c, input int start_c, input int rst_c);
        int idx;
        int slot_k;
        idx = 0; slot_k = 0;
        pattern_en = pat; pix_valid = 1'b1; pix_data = 8'hA0; start = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0;
        pattern_en = ~pat;
        for (int c = 0; c < n; c++) begin
            stop  = (c == stop_c);
            start = (c == start_c);
            rst   = (c == rst_c);
            pix_data = 8'hA0 + 8'(idx);
            pix_valid = 1'b1;
            if (pix_ready) begin
                pix_valid = (slot_k != drop_slot);
                slot_k++;
            end
            cv[c] = cam_vsync; ch[c] = cam_href; cd[c] = cam_din; cf[c] = frame_done;
            cb[c] = busy; cr[c] = pix_ready; cu[c] = underflow; cc[c] = frame_cnt;
            if (pix_ready && pix_valid) idx++;
            @(posedge pclk); #1;
        end
        stop = 1'b0; start = 1'b0; rst = 1'b0;
    endtask

    initial begin
        int cnt;
        int rises[$];

        // scen 1: pattern frame
        add(1, 0, 0, 0, 8'h00, 0);  add(1, 1, 1, 0, 8'h00, 0);  add(1, 6, 1, 0, 8'h00, 0);
        add(1, 7, 0, 0, 8'h00, 0);  add(1, 12, 0, 0, 8'h00, 0); add(1, 13, 0, 1, 8'h00, 0);
        add(1, 14, 0, 1, 8'h01, 0); add(1, 15, 0, 1, 8'h02, 0); add(1, 16, 0, 1, 8'h03, 0);
        add(1, 17, 0, 0, 8'h00, 0); add(1, 18, 0, 0, 8'h00, 0); add(1, 19, 0, 1, 8'h01, 0);
        add(1, 20, 0, 1, 8'h02, 0); add(1, 21, 0, 1, 8'h03, 0); add(1, 22, 0, 1, 8'h04, 0);
        add(1, 23, 0, 0, 8'h00, 0); add(1, 28, 0, 0, 8'h00, 0); add(1, 29, 0, 0, 8'h00, 1);
        // scen 2: clean stream
        add(2, 13, 0, 1, 8'hA0, 0); add(2, 14, 0, 1, 8'hA1, 0); add(2, 15, 0, 1, 8'hA2, 0);
        add(2, 16, 0, 1, 8'hA3, 0); add(2, 17, 0, 0, 8'h00, 0); add(2, 19, 0, 1, 8'hA4, 0);
        add(2, 20, 0, 1, 8'hA5, 0); add(2, 21, 0, 1, 8'hA6, 0); add(2, 22, 0, 1, 8'hA7, 0);
        add(2, 23, 0, 0, 8'h00, 0); add(2, 29, 0, 0, 8'h00, 1);
        // scen 3: third slot of line 0 starved
        add(3, 13, 0, 1, 8'hA0, 0); add(3, 14, 0, 1, 8'hA1, 0); add(3, 15, 0, 1, 8'h00, 0);
        add(3, 16, 0, 1, 8'hA2, 0); add(3, 17, 0, 0, 8'h00, 0); add(3, 19, 0, 1, 8'hA3, 0);
        add(3, 22, 0, 1, 8'hA6, 0);

        rst = 1'b1; start = 1'b0; stop = 1'b0; pattern_en = 1'b0;
        pix_data = 8'h00; pix_valid = 1'b0;
        do_reset();
        chk("reset vsync", 16'(cam_vsync), 16'h0);
        chk("reset href", 16'(cam_href), 16'h0);
        chk("reset din", 16'(cam_din), 16'h0);
        chk("reset busy", 16'(busy), 16'h0);
        chk("reset pix_ready", 16'(pix_ready), 16'h0);
        chk("reset frame_done", 16'(frame_done), 16'h0);
        chk("reset frame_cnt", frame_cnt, 16'h0);
        chk("reset underflow", 16'(underflow), 16'h0);

        // start together with stop in IDLE stays idle
        start = 1'b1; stop = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0; stop = 1'b0;
        @(posedge pclk); #1;
        chk("start+stop idle busy", 16'(busy), 16'h0);
        chk("start+stop idle vsync", 16'(cam_vsync), 16'h0);

        // 1: pattern frame timing
        run(31, 1'b1, -1, -1, -1, -1);
        check_table(1, "s1");
        cnt = 0;
        for (int c = 0; c < 30; c++) cnt += int'(cr[c]);
        chk("s1 pix_ready count", 16'(cnt), 16'd0);
        chk("s1 busy c0", 16'(cb[0]), 16'h1);
        chk("s1 frame_cnt c29", cc[29], 16'h0);
        chk("s1 frame_cnt c30", cc[30], 16'h1);

        // 2: stream, always valid
        do_reset();
        run(30, 1'b0, -1, -1, -1, -1);
        check_table(2, "s2");
        cnt = 0;
        for (int c = 0; c < 30; c++) cnt += int'(cr[c]);
        chk("s2 pix_ready count", 16'(cnt), 16'd8);
        chk("s2 pix_ready c12", 16'(cr[12]), 16'h1);
        chk("s2 pix_ready c16", 16'(cr[16]), 16'h0);
        chk("s2 underflow c29", 16'(cu[29]), 16'h0);

        // 3: starved slot, sticky underflow, cleared only by a new start
        do_reset();
        run(65, 1'b0, 2, 35, -1, -1);
        check_table(3, "s3");
        cnt = 0;
        for (int c = 12; c < 18; c++) cnt += int'(ch[c]);
        chk("s3 href width line0", 16'(cnt), 16'd4);
        cnt = 0;
        for (int c = 18; c < 24; c++) cnt += int'(ch[c]);
        chk("s3 href width line1", 16'(cnt), 16'd4);
        chk("s3 underflow c14", 16'(cu[14]), 16'h0);
        chk("s3 underflow c15", 16'(cu[15]), 16'h1);
        chk("s3 underflow c29", 16'(cu[29]), 16'h1);
        chk("s3 busy c59", 16'(cb[59]), 16'h1);
        chk("s3 busy c60", 16'(cb[60]), 16'h0);
        chk("s3 frame_cnt c60", cc[60], 16'h2);
        chk("s3 underflow idle", 16'(cu[64]), 16'h1);
        start = 1'b1; pattern_en = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0;
        chk("s3 underflow after start", 16'(underflow), 16'h0);
        chk("s3 busy after start", 16'(busy), 16'h1);

        // 4: stop mid-ACTIVE finishes the frame; start while busy ignored
        do_reset();
        run(40, 1'b1, -1, 14, 20, -1);
        chk("s4 frame_done c29", 16'(cf[29]), 16'h1);
        chk("s4 busy c29", 16'(cb[29]), 16'h1);
        chk("s4 busy c30", 16'(cb[30]), 16'h0);
        chk("s4 frame_cnt c30", cc[30], 16'h1);
        chk("s4 no new vsync c31", 16'(cv[31]), 16'h0);
        chk("s4 frame_cnt c39", cc[39], 16'h1);
        chk("s4 din c22", 16'(cd[22]), 16'h04);

        // 5: three back-to-back frames, then counter wrap
        do_reset();
        run(95, 1'b1, -1, -1, -1, -1);
        rises.delete();
        for (int c = 1; c < 95; c++) if (cv[c] && !cv[c-1]) rises.push_back(c);
        chk("s5 vsync rise count", 16'(rises.size()), 16'd4);
        for (int k = 0; k < rises.size() && k < 4; k++)
            chk($sformatf("s5 vsync rise %0d", k), 16'(rises[k]), 16'(1 + 30 * k));
        chk("s5 frame_cnt c89", cc[89], 16'h2);
        chk("s5 frame_cnt c90", cc[90], 16'h3);
        chk("s5 frame_done c59", 16'(cf[59]), 16'h1);

        do_reset();
        dut.frame_cnt_q = 16'hFFFF;
        run(31, 1'b1, -1, -1, -1, -1);
        chk("s5 preload c29", cc[29], 16'hFFFF);
        chk("s5 wrap c30", cc[30], 16'h0000);

        // 6: reset during HBLANK of frame 2, then identical replay of scenario 1
        do_reset();
        run(55, 1'b1, -1, -1, -1, 47);
        chk("s6 frame_cnt c47", cc[47], 16'h1);
        chk("s6 href c46", 16'(ch[46]), 16'h1);
        chk("s6 vsync c48", 16'(cv[48]), 16'h0);
        chk("s6 href c48", 16'(ch[48]), 16'h0);
        chk("s6 din c48", 16'(cd[48]), 16'h0);
        chk("s6 busy c48", 16'(cb[48]), 16'h0);
        chk("s6 frame_done c48", 16'(cf[48]), 16'h0);
        chk("s6 frame_cnt c48", cc[48], 16'h0);
        chk("s6 pix_ready c48", 16'(cr[48]), 16'h0);
        chk("s6 busy c54", 16'(cb[54]), 16'h0);
        run(31, 1'b1, -1, -1, -1, -1);
        check_table(1, "s6");
        chk("s6 frame_cnt c30", cc[30], 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
